// File: rtl/piso_tx_sequencer.sv
// Parallel-in/serial-out transmit sequencer: one-word holding register, programmable bit period.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_tx_sequencer #(
  parameter int WIDTH     = 4,
  parameter int DIV_W     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             bit_strobe,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int BC_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               hold_full_q, hold_full_d;
  logic [WIDTH-1:0]   hold_q, hold_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [DIV_W-1:0]   div_rld_q, div_rld_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic               serial_out_q, serial_out_d;
  logic               bit_strobe_q, bit_strobe_d;
  logic               frame_start_q, frame_start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               load;
  logic               end_frame;
`ifdef PISO_PARITY_EN
  logic               par_q, par_d;
`endif

  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  always_comb begin
    state_d       = state_q;
    hold_full_d   = hold_full_q;
    hold_d        = hold_q;
    shreg_d       = shreg_q;
    div_rld_d     = div_rld_q;
    div_cnt_d     = div_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    serial_out_d  = serial_out_q;
    bit_strobe_d  = 1'b0;
    frame_start_d = 1'b0;
    busy_d        = busy_q;
    done_d        = 1'b0;
    load          = 1'b0;
    end_frame     = 1'b0;
`ifdef PISO_PARITY_EN
    par_d         = par_q;
`endif

    if (in_valid && !hold_full_q) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (hold_full_q) load = 1'b1;
      end
      S_SHIFT: begin
        if (div_cnt_q == '0) begin
          div_cnt_d = div_rld_q;
          if (bit_cnt_q == BC_W'(WIDTH - 1)) begin
`ifdef PISO_PARITY_EN
            state_d      = S_PARITY;
            serial_out_d = par_q;
            bit_strobe_d = 1'b1;
`else
            end_frame    = 1'b1;
`endif
          end else begin
            shreg_d      = shift_word(shreg_q);
            serial_out_d = lead_bit(shift_word(shreg_q));
            bit_cnt_d    = bit_cnt_q + BC_W'(1);
            bit_strobe_d = 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q - DIV_W'(1);
        end
      end
      S_PARITY: begin
`ifdef PISO_PARITY_EN
        if (div_cnt_q == '0) end_frame = 1'b1;
        else                 div_cnt_d = div_cnt_q - DIV_W'(1);
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // A held word at end of frame starts the next frame with no idle gap.
    if (end_frame) begin
      done_d = 1'b1;
      if (hold_full_q) begin
        load = 1'b1;
      end else begin
        state_d      = S_IDLE;
        busy_d       = 1'b0;
        serial_out_d = 1'b0;
      end
    end

    if (load) begin
      shreg_d       = hold_q;
      serial_out_d  = lead_bit(hold_q);
      hold_full_d   = 1'b0;
      div_rld_d     = div;
      div_cnt_d     = div;
      bit_cnt_d     = '0;
      state_d       = S_SHIFT;
      busy_d        = 1'b1;
      frame_start_d = 1'b1;
      bit_strobe_d  = 1'b1;
`ifdef PISO_PARITY_EN
      par_d         = ^hold_q;
`endif
    end
  end

  // Control state: reset to idle, discarding any held or in-flight word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      hold_full_q   <= 1'b0;
      div_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      serial_out_q  <= 1'b0;
      bit_strobe_q  <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_full_q   <= hold_full_d;
      div_cnt_q     <= div_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      serial_out_q  <= serial_out_d;
      bit_strobe_q  <= bit_strobe_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Data registers are only consumed when their control flags say so.
  always_ff @(posedge clk) begin
    hold_q    <= hold_d;
    shreg_q   <= shreg_d;
    div_rld_q <= div_rld_d;
`ifdef PISO_PARITY_EN
    par_q     <= par_d;
`endif
  end

  assign in_ready    = ~hold_full_q;
  assign serial_out  = serial_out_q;
  assign bit_strobe  = bit_strobe_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_piso_tx_sequencer.sv
// Directed bench for piso_tx_sequencer (WIDTH=4, MSB first); parity-aware via PISO_PARITY_EN.
module tb_piso_tx_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] div;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready, serial_out, bit_strobe, frame_start, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  piso_tx_sequencer #(.WIDTH(4), .DIV_W(8), .MSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .div(div), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .serial_out(serial_out), .bit_strobe(bit_strobe),
    .frame_start(frame_start), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at the negedge right after the load edge; returns at the negedge after the frame ends.
  task automatic check_frame(input logic [3:0] w, input int dv, input bit b2b, input bit drop_div);
    logic [4:0] bits;
    int nb;
    bits = '0;
    nb = 4;
    for (int i = 0; i < 4; i++) bits[i] = w[3 - i];
`ifdef PISO_PARITY_EN
    bits[4] = ^w;
    nb = 5;
`endif
    for (int i = 0; i < nb; i++) begin
      for (int c = 0; c <= dv; c++) begin
        check_eq($sformatf("ser w%0h b%0d c%0d", w, i, c), serial_out, bits[i]);
        check_eq($sformatf("strobe b%0d c%0d", i, c), bit_strobe, (c == 0));
        check_eq($sformatf("fstart b%0d c%0d", i, c), frame_start, (i == 0 && c == 0));
        check_eq($sformatf("busy b%0d c%0d", i, c), busy, 1);
        check_eq($sformatf("done b%0d c%0d", i, c), done, (i == 0 && c == 0) ? b2b : 1'b0);
        if (drop_div && i == 1 && c == 0) div = 8'd0;
        @(negedge clk);
      end
    end
  endtask

  task automatic check_idle_after(input string tag);
    check_eq({tag, " done"}, done, 1);
    check_eq({tag, " busy"}, busy, 0);
    check_eq({tag, " ser"}, serial_out, 0);
    check_eq({tag, " rdy"}, in_ready, 1);
    @(negedge clk);
    check_eq({tag, " done drop"}, done, 0);
  endtask

  initial begin
    rst = 1'b1; div = 8'd0; in_data = 4'd0; in_valid = 1'b0;

    // 1: reset values
    @(negedge clk); @(negedge clk);
    check_eq("rst ser", serial_out, 0);
    check_eq("rst rdy", in_ready, 1);
    check_eq("rst busy", busy, 0);
    check_eq("rst done", done, 0);
    check_eq("rst strobe", bit_strobe, 0);
    check_eq("rst fstart", frame_start, 0);
    rst = 1'b0;
    @(negedge clk);

    // 2: single word, div=0
    in_valid = 1'b1; in_data = 4'b1010;
    @(negedge clk);
    in_valid = 1'b0; in_data = 4'b0111;
    check_eq("t2 rdy held", in_ready, 0);
    check_eq("t2 busy pre", busy, 0);
    check_eq("t2 ser pre", serial_out, 0);
    @(negedge clk);
    check_frame(4'b1010, 0, 1'b0, 1'b0);
    check_idle_after("t2");

    // 3: back-to-back words
    in_valid = 1'b1; in_data = 4'b1010;
    @(negedge clk);
    in_data = 4'b1100;
    check_eq("t3 rdy first", in_ready, 0);
    @(negedge clk);
    check_eq("t3 rdy free", in_ready, 1);
    fork
      begin
        @(negedge clk);
        check_eq("t3 rdy second", in_ready, 0);
        in_valid = 1'b0;
      end
    join_none
    check_frame(4'b1010, 0, 1'b0, 1'b0);
    check_frame(4'b1100, 0, 1'b1, 1'b0);
    check_idle_after("t3");

    // 4: div=2, div change mid-frame ignored
    div = 8'd2; in_valid = 1'b1; in_data = 4'b1001;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check_frame(4'b1001, 2, 1'b0, 1'b1);
    check_idle_after("t4");

    // 6-style extra frame (parity 1 when enabled)
    div = 8'd0; in_valid = 1'b1; in_data = 4'b1110;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check_frame(4'b1110, 0, 1'b0, 1'b0);
    check_idle_after("t6");

    // 5: reset mid-frame with a word held
    in_valid = 1'b1; in_data = 4'b1010;
    @(negedge clk);
    in_data = 4'b0110;
    @(negedge clk);
    check_eq("t5 bit0", serial_out, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("t5 bit1", serial_out, 0);
    check_eq("t5 held", in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("t5 ser", serial_out, 0);
    check_eq("t5 rdy", in_ready, 1);
    check_eq("t5 busy", busy, 0);
    check_eq("t5 done", done, 0);
    check_eq("t5 strobe", bit_strobe, 0);
    check_eq("t5 fstart", frame_start, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_eq($sformatf("t5 quiet busy %0d", k), busy, 0);
      check_eq($sformatf("t5 quiet ser %0d", k), serial_out, 0);
      check_eq($sformatf("t5 quiet fs %0d", k), frame_start, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
